// File: rtl/environment_row_reader.sv
// Read side of the 16x16 Game of Life environment.
// Snapshots one generation on request, streams it out row by row over a
// valid/ready handshake, and reports the frame's live-cell population with a
// single-cycle end-of-frame pulse.
module environment_row_reader #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int ROW_IDX_W = 4,   // must equal clog2(GRID_H)
  parameter int POP_W     = 9    // must hold GRID_W*GRID_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GRID_W*GRID_H-1:0]   env_in,
  input  logic                       frame_req,
  output logic                       frame_busy,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [GRID_W-1:0]          row_data,
  output logic [ROW_IDX_W-1:0]       row_idx,
  output logic                       row_last,
  output logic [POP_W-1:0]           pop_count,
  output logic                       frame_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(GRID_H - 1);

  logic [1:0]                 r_state;
  logic [GRID_W*GRID_H-1:0]   r_snap;   // frozen copy; env_in may change mid-frame
  logic [ROW_IDX_W-1:0]       r_row;
  logic [POP_W-1:0]           r_acc;    // population of rows transferred so far
  logic [POP_W-1:0]           r_pop;    // population of the last completed frame

  logic [GRID_W-1:0]          w_row;
  logic [POP_W-1:0]           w_row_pop;
  logic [POP_W-1:0]           w_acc_next;
  logic                       w_send;
  logic                       w_xfer;
  logic                       w_at_last;

  assign w_send     = (r_state == ST_SEND);
  assign w_xfer     = w_send && row_ready;
  assign w_at_last  = (r_row == LAST_ROW);
  assign w_row      = r_snap[int'(r_row)*GRID_W +: GRID_W];
  assign w_acc_next = r_acc + w_row_pop;

  // Count live cells of the row currently presented, at full POP_W width.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred;
    // blocking '=' is correct here because the loop builds the sum step by step.
    w_row_pop = '0;
    for (int c = 0; c < GRID_W; c++) begin
      w_row_pop = w_row_pop + POP_W'(w_row[c]);
    end
  end

  // Frame sequencing: snapshot on request, advance on each transfer, publish
  // the population when the last row leaves.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking '<=' so every register samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_row   <= '0;
      r_acc   <= '0;
      r_pop   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (frame_req) begin
            r_snap  <= env_in;
            r_row   <= '0;
            r_acc   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_acc <= w_acc_next;
            if (w_at_last) begin
              r_pop   <= w_acc_next;
              r_row   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded straight from registered state; row fields read as
  // zero whenever no row is offered.
  assign frame_busy = (r_state != ST_IDLE);
  assign row_valid  = w_send;
  assign row_data   = w_send ? w_row : '0;
  assign row_idx    = r_row;
  assign row_last   = w_send && w_at_last;
  assign pop_count  = r_pop;
  assign frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_environment_row_reader.sv
// Randomised bench for environment_row_reader. A transaction-level model keeps
// the rows of each accepted frame in a queue and predicts, every cycle, what
// the handshake, the end-of-frame pulse and the population must show.
module tb_environment_row_reader;

  localparam int GW = 16;
  localparam int GH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [GW*GH-1:0] env_in;
  logic             frame_req;
  logic             frame_busy;
  logic             row_valid;
  logic             row_ready;
  logic [GW-1:0]    row_data;
  logic [3:0]       row_idx;
  logic             row_last;
  logic [8:0]       pop_count;
  logic             frame_done;

  environment_row_reader dut (
    .clk        (clk),
    .rst        (rst),
    .env_in     (env_in),
    .frame_req  (frame_req),
    .frame_busy (frame_busy),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .pop_count  (pop_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [GW-1:0] exp_rows[$];   // rows still to be transferred, in order
  int            exp_idx;
  bit            done_due;      // frame_done expected in the current cycle
  int            pop_pending;   // population of the frame being streamed
  int            last_pop;      // value pop_count must show
  bit            rst_prev;
  int            frames_started;
  int            frames_done_seen;
  bit            saw_row7;
  logic [GW-1:0] got_rows[GH];

  function automatic bit model_idle();
    return (exp_rows.size() == 0) && !done_due;
  endfunction

  // Check outputs mid-cycle, then advance the model using the inputs that
  // will be sampled at the coming rising edge.
  always @(negedge clk) begin
    bit next_done;
    if (frame_done === 1'b1) frames_done_seen++;
    if (rst_prev) begin
      last_pop = 0;
      check("rst_busy",  frame_busy, 0);
      check("rst_valid", row_valid,  0);
      check("rst_data",  row_data,   0);
      check("rst_idx",   row_idx,    0);
      check("rst_last",  row_last,   0);
      check("rst_pop",   pop_count,  0);
      check("rst_done",  frame_done, 0);
    end else begin
      check("frame_done", frame_done, done_due);
      if (done_due) last_pop = pop_pending;
      check("pop_count",  pop_count,  last_pop);
      check("row_valid",  row_valid,  exp_rows.size() != 0);
      check("frame_busy", frame_busy, (exp_rows.size() != 0) || done_due);
      if (exp_rows.size() != 0) begin
        check("row_idx",  row_idx,  exp_idx);
        check("row_data", row_data, exp_rows[0]);
        check("row_last", row_last, exp_idx == GH - 1);
      end
    end

    next_done = 1'b0;
    if (rst) begin
      exp_rows.delete();
    end else if (model_idle()) begin
      if (frame_req) begin
        for (int r = 0; r < GH; r++) exp_rows.push_back(env_in[r*GW +: GW]);
        pop_pending = $countones(env_in);
        exp_idx = 0;
        frames_started++;
      end
    end else if (exp_rows.size() != 0 && row_ready) begin
      got_rows[exp_idx] = row_data;
      if (exp_idx == 7) saw_row7 = 1'b1;
      void'(exp_rows.pop_front());
      exp_idx++;
      if (exp_rows.size() == 0) next_done = 1'b1;
    end
    done_due = rst ? 1'b0 : next_done;
    rst_prev = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [GW*GH-1:0] rand_env();
    logic [GW*GH-1:0] e;
    for (int i = 0; i < GW*GH/32; i++) e[i*32 +: 32] = $urandom;
    return e;
  endfunction

  // Run until the model says the frame has finished; optionally randomise
  // row_ready and frame_req, and scribble over env_in while streaming.
  task automatic wait_idle(input bit rnd_ready, input bit req_noise, input bit scramble);
    int n = 0;
    while (!model_idle() && n < 400) begin
      if (rnd_ready) row_ready = ($urandom_range(0, 3) != 0);
      if (req_noise) frame_req = $urandom_range(0, 1);
      if (scramble)  env_in    = rand_env();
      tick();
      n++;
    end
    frame_req = 1'b0;
    if (n >= 400) check("idle_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [GW*GH-1:0] e, input bit rnd_ready, input bit scramble);
    env_in    = e;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    if (scramble) env_in = '1;
    wait_idle(rnd_ready, 1'b0, 1'b0);
    row_ready = 1'b1;
    tick();
  endtask

  logic [GW*GH-1:0] glider;
  logic [GW*GH-1:0] pop12;

  initial begin
    rst       = 1'b1;
    frame_req = 1'b1;   // rst must win over a simultaneous request
    row_ready = 1'b0;
    env_in    = '1;
    repeat (3) tick();
    check("init_valid", row_valid,  0);
    check("init_busy",  frame_busy, 0);
    check("init_pop",   pop_count,  0);
    rst       = 1'b0;
    frame_req = 1'b0;
    tick();

    // All zero, ready tied high.
    row_ready = 1'b1;
    run_frame('0, 1'b0, 1'b0);
    check("zero_pop", pop_count, 0);

    // All ones: population 256 without wrap.
    run_frame('1, 1'b0, 1'b0);
    check("ones_pop", pop_count, 9'h100);

    // Glider with stalls; env_in forced to all ones after the request.
    glider = '0;
    glider[1]      = 1'b1;
    glider[GW+2]   = 1'b1;
    glider[2*GW]   = 1'b1;
    glider[2*GW+1] = 1'b1;
    glider[2*GW+2] = 1'b1;
    run_frame(glider, 1'b1, 1'b1);
    check("glider_row0", got_rows[0], 16'h0002);
    check("glider_row1", got_rows[1], 16'h0004);
    check("glider_row2", got_rows[2], 16'h0007);
    check("glider_row3", got_rows[3], 16'h0000);
    check("glider_pop",  pop_count,   5);

    // Back-to-back: pop 5 then pop 12; pop_count holds 5 while frame 2 streams.
    pop12 = '0;
    pop12[5*GW +: GW] = 16'h0FFF;
    run_frame(glider, 1'b0, 1'b0);
    check("b2b_pop1", pop_count, 5);
    run_frame(pop12, 1'b1, 1'b0);
    check("b2b_pop2", pop_count, 12);

    // frame_req held high: frames repeat with one idle cycle in between.
    env_in    = rand_env();
    frame_req = 1'b1;
    repeat (60) tick();
    frame_req = 1'b0;
    wait_idle(1'b0, 1'b0, 1'b0);
    tick();

    // Reset right after the row-7 transfer.
    saw_row7  = 1'b0;
    env_in    = rand_env();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    for (int n = 0; n < 100 && !saw_row7; n++) tick();
    check("row7_seen", saw_row7, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", row_valid,  0);
    check("mid_rst_done",  frame_done, 0);
    check("mid_rst_pop",   pop_count,  0);
    rst = 1'b0;
    tick();
    run_frame(pop12, 1'b1, 1'b0);
    check("post_rst_pop", pop_count, 12);

    // Random frames with random stalls, stray requests and env_in churn.
    for (int f = 0; f < 6; f++) begin
      env_in    = rand_env();
      frame_req = 1'b1;
      tick();
      wait_idle(1'b1, 1'b1, 1'b1);
      wait_idle(1'b1, 1'b0, 1'b0);
      row_ready = 1'b1;
      tick();
    end

    // Exactly one frame (the reset one) must have gone without frame_done.
    tick();
    check("frame_count", frames_done_seen, frames_started - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
